// File: rtl/fetch_bundle_queue.sv
// fetch_bundle_queue
//   Multi-issue instruction fetch unit. It reads aligned bundles of ISSUE_W
//   instructions from a synchronous 1-cycle-latency instruction memory and
//   buffers them in a DEPTH-entry bundle queue. Decode takes one bundle per
//   cycle from the head of the queue. A branch redirect flushes the queue,
//   drops the read that is returning, and pads the slots in front of an
//   unaligned target with LNOP.
//
//   Handshake: a bundle transfers on a rising edge where out_valid and
//   out_ready are both high. out_valid never depends on out_ready. While
//   out_ready is low the head bundle and every out_* signal hold steady.
//
// Ports
//   clock          in   rising-edge clock
//   reset          in   asynchronous, active-high reset
//   redirect       in   branch taken; load redirect_pc
//   redirect_pc    in   branch target (4-byte aligned)
//   imem_req       out  instruction memory read request this cycle
//   imem_addr      out  bundle-aligned read address
//   imem_rdata     in   bundle data, valid the cycle after imem_req; slot 0 in MSBs
//   out_valid      out  head bundle valid
//   out_ready      in   decode accepts the head bundle
//   out_pc         out  address of slot 0 of the head bundle
//   out_inst       out  head bundle instructions; slot 0 in MSBs
//   out_slot_mask  out  per-slot live bit (MSB = slot 0); 0 = LNOP padding
//   queue_count    out  occupied queue entries
module fetch_bundle_queue #(
    parameter int                ADDR_W    = 32,
    parameter int                INST_W    = 32,
    parameter int                ISSUE_W   = 2,
    parameter int                DEPTH     = 4,
    parameter int                MEM_BYTES = 2048,
    parameter logic [INST_W-1:0] LNOP      = 32'h00200000
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        redirect,
    input  logic [ADDR_W-1:0]           redirect_pc,
    output logic                        imem_req,
    output logic [ADDR_W-1:0]           imem_addr,
    input  logic [ISSUE_W*INST_W-1:0]   imem_rdata,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ADDR_W-1:0]           out_pc,
    output logic [ISSUE_W*INST_W-1:0]   out_inst,
    output logic [ISSUE_W-1:0]          out_slot_mask,
    output logic [$clog2(DEPTH):0]      queue_count
);

    localparam int B      = ISSUE_W * 4;
    localparam int BUN_W  = ISSUE_W * INST_W;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int OCC_W  = CNT_W + 1;
    localparam int SLOT_W = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1;

    // Queue storage: each entry keeps its own PC tag and slot mask.
    logic [ADDR_W-1:0]  r_q_pc   [DEPTH];
    logic [BUN_W-1:0]   r_q_inst [DEPTH];
    logic [ISSUE_W-1:0] r_q_mask [DEPTH];

    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [ADDR_W-1:0]  r_rsp_pc;     // address tag of the read in flight
    logic               r_inflight;
    logic               r_pad;
    logic [SLOT_W-1:0]  r_pad_slot;   // slot index of the redirect target

    logic [OCC_W-1:0]   w_occ;
    logic               w_req;
    logic               w_push;
    logic               w_pop;
    logic [ADDR_W-1:0]  w_pc_next;
    logic [ADDR_W-1:0]  w_rd_aligned;
    logic [SLOT_W-1:0]  w_rd_slot;
    logic [BUN_W-1:0]   w_fill_inst;
    logic [ISSUE_W-1:0] w_fill_mask;

    // Entries already queued and the read still in flight both claim a slot,
    // so a returning response always finds room in the queue.
    assign w_occ  = OCC_W'(r_count) + OCC_W'(r_inflight);
    assign w_req  = !reset && !redirect && (w_occ < OCC_W'(DEPTH));
    assign w_push = r_inflight && !redirect;
    assign w_pop  = (r_count != '0) && out_ready && !redirect;

    assign w_pc_next = (r_fetch_pc >= ADDR_W'(MEM_BYTES - B)) ? '0
                                                              : r_fetch_pc + ADDR_W'(B);

    assign w_rd_aligned = redirect_pc & ~ADDR_W'(B - 1);
    assign w_rd_slot    = SLOT_W'((redirect_pc >> 2) & ADDR_W'(ISSUE_W - 1));

    // Slot i sits at bit (ISSUE_W-1-i) of the mask and in the matching
    // INST_W field of the bundle, counted from the MSB end.
    always_comb begin
        w_fill_inst = imem_rdata;
        w_fill_mask = '1;
        for (int i = 0; i < ISSUE_W; i++) begin
            if (r_pad && (i < int'(r_pad_slot))) begin
                w_fill_inst[(ISSUE_W-1-i)*INST_W +: INST_W] = LNOP;
                w_fill_mask[ISSUE_W-1-i]                    = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_fetch_pc <= '0;
            r_rsp_pc   <= '0;
            r_inflight <= 1'b0;
            r_pad      <= 1'b0;
            r_pad_slot <= '0;
        end else if (redirect) begin
            // Flush; the response landing at this edge is not pushed, and no
            // request is issued while redirect is high.
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
            r_fetch_pc <= w_rd_aligned;
            r_pad      <= (w_rd_slot != '0);
            r_pad_slot <= w_rd_slot;
        end else begin
            r_inflight <= w_req;
            if (w_req) begin
                r_fetch_pc <= w_pc_next;
                r_rsp_pc   <= r_fetch_pc;
            end
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
                r_pad  <= 1'b0;
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q_pc[i]   <= '0;
                r_q_inst[i] <= {ISSUE_W{LNOP}};
                r_q_mask[i] <= '0;
            end
        end else if (w_push) begin
            r_q_pc[r_tail]   <= r_rsp_pc;
            r_q_inst[r_tail] <= w_fill_inst;
            r_q_mask[r_tail] <= w_fill_mask;
        end
    end

    assign imem_req      = w_req;
    assign imem_addr     = r_fetch_pc;
    assign out_valid     = (r_count != '0);
    assign out_pc        = r_q_pc[r_head];
    assign out_inst      = r_q_inst[r_head];
    assign out_slot_mask = r_q_mask[r_head];
    assign queue_count   = r_count;

endmodule

// File: tb/tb_fetch_bundle_queue.sv
// tb_fetch_bundle_queue
//   Directed bench for fetch_bundle_queue with ISSUE_W=2, DEPTH=4,
//   MEM_BYTES=2048. The instruction memory returns C0DE0000 | byte_addr for
//   each word, so every expected bundle below is written out by hand.
//   Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_fetch_bundle_queue;

  localparam logic [31:0] LNOP = 32'h00200000;

  logic        clock;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [63:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [63:0] out_inst;
  logic [1:0]  out_slot_mask;
  logic [2:0]  queue_count;

  int checks;
  int errors;
  logic [31:0] exp_q[$];

  fetch_bundle_queue dut (
    .clock         (clock),
    .reset         (reset),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_inst      (out_inst),
    .out_slot_mask (out_slot_mask),
    .queue_count   (queue_count)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // synchronous instruction memory, 1-cycle latency
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE0000 | {21'd0, a[10:0]};
  endfunction

  always @(posedge clock) begin
    if (imem_req) imem_rdata <= {mem_word(imem_addr), mem_word(imem_addr + 32'd4)};
  end

  // checking task
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(negedge clock);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   64'(imem_req),      64'd0);
    chk({tag, "_addr"},  64'(imem_addr),     64'd0);
    chk({tag, "_valid"}, 64'(out_valid),     64'd0);
    chk({tag, "_pc"},    64'(out_pc),        64'd0);
    chk({tag, "_inst"},  out_inst,           {LNOP, LNOP});
    chk({tag, "_mask"},  64'(out_slot_mask), 64'd0);
    chk({tag, "_count"}, 64'(queue_count),   64'd0);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    out_ready   = 1'b1;
    imem_rdata  = '0;

    next_cycle(); #1;
    chk_reset_outputs("rst");

    // stream from address 0
    next_cycle(); reset = 1'b0; #1;
    chk("s0_req",   64'(imem_req),  64'd1);
    chk("s0_addr",  64'(imem_addr), 64'd0);
    chk("s0_valid", 64'(out_valid), 64'd0);
    next_cycle(); #1;
    chk("s1_addr",  64'(imem_addr), 64'd8);
    chk("s1_valid", 64'(out_valid), 64'd0);
    next_cycle(); #1;
    chk("s2_valid", 64'(out_valid),     64'd1);
    chk("s2_pc",    64'(out_pc),        64'd0);
    chk("s2_mask",  64'(out_slot_mask), 64'd3);
    chk("s2_inst",  out_inst,           64'hC0DE0000_C0DE0004);
    chk("s2_addr",  64'(imem_addr),     64'd16);
    next_cycle(); #1;
    chk("s3_pc",    64'(out_pc),        64'd8);
    chk("s3_addr",  64'(imem_addr),     64'd24);

    // stall for 10 cycles: head stays put, queue fills to 4, fetch stops
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      next_cycle(); #1;
      chk("stall_pc",   64'(out_pc),   64'd8);
      chk("stall_inst", out_inst,      64'hC0DE0008_C0DE000C);
    end
    chk("stall_count", 64'(queue_count), 64'd4);
    chk("stall_req",   64'(imem_req),    64'd0);

    // release: four back-to-back pops in PC order
    exp_q.push_back(32'd8);
    exp_q.push_back(32'd16);
    exp_q.push_back(32'd24);
    exp_q.push_back(32'd32);
    out_ready = 1'b1;
    chk("pop_valid", 64'(out_valid), 64'd1);
    chk("pop_pc",    64'(out_pc),    64'(exp_q.pop_front()));
    while (exp_q.size() != 0) begin
      next_cycle(); #1;
      chk("pop_valid", 64'(out_valid), 64'd1);
      chk("pop_pc",    64'(out_pc),    64'(exp_q.pop_front()));
    end

    // unaligned redirect to 0x104 with a read in flight
    next_cycle(); #1;
    chk("pre_rd_req",  64'(imem_req),  64'd1);
    chk("pre_rd_addr", 64'(imem_addr), 64'd64);
    chk("pre_rd_pc",   64'(out_pc),    64'd40);
    redirect = 1'b1; redirect_pc = 32'h104; #1;
    chk("rd_req_low", 64'(imem_req), 64'd0);
    next_cycle(); redirect = 1'b0; #1;
    chk("rd1_req",   64'(imem_req),    64'd1);
    chk("rd1_addr",  64'(imem_addr),   64'h100);
    chk("rd1_valid", 64'(out_valid),   64'd0);
    chk("rd1_count", 64'(queue_count), 64'd0);
    next_cycle(); #1;
    chk("rd2_valid", 64'(out_valid), 64'd0);
    chk("rd2_addr",  64'(imem_addr), 64'h108);
    next_cycle(); #1;
    chk("rd3_valid", 64'(out_valid),     64'd1);
    chk("rd3_pc",    64'(out_pc),        64'h100);
    chk("rd3_mask",  64'(out_slot_mask), 64'd1);
    chk("rd3_inst",  out_inst,           {LNOP, 32'hC0DE0104});
    next_cycle(); #1;
    chk("rd4_pc",    64'(out_pc),        64'h108);
    chk("rd4_mask",  64'(out_slot_mask), 64'd3);

    // aligned redirect to 0x40 while the head is being handshaken
    chk("ra_hs", 64'(out_valid && out_ready), 64'd1);
    redirect = 1'b1; redirect_pc = 32'h40;
    next_cycle(); redirect = 1'b0; #1;
    chk("ra1_count", 64'(queue_count), 64'd0);
    chk("ra1_valid", 64'(out_valid),   64'd0);
    chk("ra1_addr",  64'(imem_addr),   64'h40);
    next_cycle(); #1;
    chk("ra2_valid", 64'(out_valid), 64'd0);
    next_cycle(); #1;
    chk("ra3_valid", 64'(out_valid),     64'd1);
    chk("ra3_pc",    64'(out_pc),        64'h40);
    chk("ra3_mask",  64'(out_slot_mask), 64'd3);
    chk("ra3_inst",  out_inst,           64'hC0DE0040_C0DE0044);
    next_cycle(); #1;
    chk("ra4_pc",    64'(out_pc),        64'h48);

    // wrap at the end of memory
    redirect = 1'b1; redirect_pc = 32'd2040;
    next_cycle(); redirect = 1'b0; #1;
    chk("wr1_addr", 64'(imem_addr), 64'd2040);
    next_cycle(); #1;
    chk("wr2_addr", 64'(imem_addr), 64'd0);
    next_cycle(); #1;
    chk("wr3_pc",   64'(out_pc),   64'd2040);
    chk("wr3_inst", out_inst,      64'hC0DE07F8_C0DE07FC);
    next_cycle(); #1;
    chk("wr4_pc",   64'(out_pc),   64'd0);
    chk("wr4_inst", out_inst,      64'hC0DE0000_C0DE0004);

    // asynchronous reset with the queue half full
    out_ready = 1'b0;
    next_cycle(); #1;
    chk("half_count", 64'(queue_count), 64'd2);
    #2 reset = 1'b1;
    #1;
    chk_reset_outputs("arst");
    next_cycle(); reset = 1'b0; #1;
    chk("post_req",  64'(imem_req),  64'd1);
    chk("post_addr", 64'(imem_addr), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
